// File: rtl/fp_pipe_pkg.sv
// fp_pipe_pkg: shared state encodings and payload widths for the FP inter-stage pipeline registers
package fp_pipe_pkg;
    // State is the pair {skid_v, main_v}, so the encodings double as the valid bits
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL1 = 2'b01;
    localparam logic [1:0] ST_FULL2 = 2'b11;
    // mul->add: rm, sign, exp10, inf/nan, 23-bit frac, two 24-bit product halves
    localparam int FP_M2A_DW = 2 + 1 + 10 + 1 + 23 + 24 + 24;
    // add->round: rm, sign, exp10, inf, nan, 28-bit sum with guard/round/sticky
    localparam int FP_A2R_DW = 2 + 1 + 10 + 1 + 1 + 28;
endpackage

// File: rtl/fp_pipe_data_reg.sv
// fp_pipe_data_reg: DW-wide enable register, optionally cleared on reset
module fp_pipe_data_reg #(
    parameter int DW          = 64,
    parameter bit RST_PAYLOAD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    generate
        if (RST_PAYLOAD) begin : g_rst
            // Payload cleared on reset, loads only when enabled
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) q <= '0;
                else if (en) q <= d;
        end else begin : g_nrst
            logic unused_rst;
            assign unused_rst = rst_n;
            // Payload left uninitialised on reset to save the reset fan-out
            always_ff @(posedge clk)
                if (en) q <= d;
        end
    endgenerate
endmodule

// File: rtl/fp_pipe_skid_reg.sv
// fp_pipe_skid_reg: elastic valid/ready pipeline register with optional skid entry and flush
module fp_pipe_skid_reg
    import fp_pipe_pkg::*;
#(
    parameter int DW          = 64,
    parameter bit SKID        = 1,
    parameter bit RST_PAYLOAD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);
    logic          main_v, skid_v, main_en, skid_en, acc, take;
    logic [1:0]    st, nxt;
    logic [DW-1:0] main_q, skid_q, main_d;

    assign st        = {skid_v, main_v};
    assign in_ready  = (SKID ? !skid_v : (!main_v | out_ready)) & !flush;
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_q;
    // A full skid always refills main; otherwise main loads straight from upstream
    assign main_d    = skid_v ? skid_q : in_data;

    // Next state and payload load enables; flush overrides every transition
    always_comb begin
        nxt     = st;
        main_en = 1'b0;
        skid_en = 1'b0;
        if (flush) begin
            nxt = ST_EMPTY;
        end else if (!SKID) begin
            main_en = acc;
            nxt     = {1'b0, acc | (main_v & !take)};
        end else begin
            case (st)
                ST_EMPTY: begin
                    main_en = acc;
                    nxt     = acc ? ST_FULL1 : ST_EMPTY;
                end
                ST_FULL1: begin
                    main_en = acc & take;
                    skid_en = acc & !take;
                    nxt     = (acc & !take) ? ST_FULL2 : (!acc & take) ? ST_EMPTY : ST_FULL1;
                end
                ST_FULL2: begin
                    main_en = take;
                    nxt     = take ? ST_FULL1 : ST_FULL2;
                end
                default: nxt = ST_EMPTY;
            endcase
        end
    end

    // Valid bits and occupancy, lost immediately on reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            occ    <= 2'd0;
        end else begin
            main_v <= nxt[0];
            skid_v <= nxt[1];
            occ    <= {1'b0, nxt[0]} + {1'b0, nxt[1]};
        end

    fp_pipe_data_reg #(.DW(DW), .RST_PAYLOAD(RST_PAYLOAD)) u_main (
        .clk(clk), .rst_n(rst_n), .en(main_en), .d(main_d), .q(main_q)
    );

    fp_pipe_data_reg #(.DW(DW), .RST_PAYLOAD(RST_PAYLOAD)) u_skid (
        .clk(clk), .rst_n(rst_n), .en(skid_en), .d(in_data), .q(skid_q)
    );
endmodule
